jtkcpu_stack_seq: RTL and testbench

// Sequences the byte-wise memory transfers of PSHS/PSHU/PULS/PULU, interrupt entry and RTI.
// The ucode issues a start pulse with a register mask. This block then walks the mask in
// 6809 order, drives the memory interface one byte at a time, updates the active stack

---
 rtl/jtkcpu_stack_seq_if.sv | 21 ++
 rtl/jtkcpu_stack_seq.sv | 161 ++++++++++++++++
 tb/tb_jtkcpu_stack_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtkcpu_stack_seq_if.sv
// rtl/jtkcpu_stack_seq_if.sv - byte-wide memory bus between stack sequencer and memory
interface jtkcpu_stack_seq_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dout;
    logic          mem_busy;
    logic [7:0]    mem_din;

    modport master (
        output mem_req, mem_we, mem_addr, mem_dout,
        input  mem_busy, mem_din
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_dout,
        output mem_busy, mem_din
    );
endinterface

// File: rtl/jtkcpu_stack_seq.sv
// rtl/jtkcpu_stack_seq.sv - 6809-style push/pull byte sequencer for PSHS/PSHU/PULS/PULU/RTI
module jtkcpu_stack_seq #(
    parameter int AW = 16
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          psh_go,
    input  logic          pul_go,
    input  logic [7:0]    mask,
    input  logic          use_u,
    input  logic [AW-1:0] sp_in,
    input  logic [15:0]   pc,
    input  logic [15:0]   u,
    input  logic [15:0]   s,
    input  logic [15:0]   y,
    input  logic [15:0]   x,
    input  logic [7:0]    dp,
    input  logic [7:0]    b,
    input  logic [7:0]    a,
    input  logic [7:0]    cc,
    jtkcpu_stack_seq_if.master mem,
    output logic [AW-1:0] sp_out,
    output logic          sp_we,
    output logic          ld_en,
    output logic [2:0]    ld_sel,
    output logic          ld_hi,
    output logic [7:0]    ld_data,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

    state_t           st, st_nxt;
    logic             dir_psh;      // latched direction: 1 push, 0 pull
    logic [11:0]      pend;         // bytes still to move, bit 0 = first in transfer order
    logic [11:0][7:0] byte_q;       // push bytes in push order (index 0 = PCL)
    logic [11:0]      psh_vec;
    logic [11:0]      pul_vec;
    logic [3:0]       cur_idx;
    logic [11:0]      cur_bit;
    logic [3:0]       slot;         // current byte expressed as push-order index
    logic [2:0]       cur_sel;
    logic             cur_hi;
    logic             start;
    logic             conflict;
    logic             step;
    logic             last;
    logic [15:0]      other_sp;

    assign start    = cen && (st == IDLE) && (psh_go ^ pul_go);
    assign conflict = cen && (st == IDLE) && psh_go && pul_go;
    assign other_sp = use_u ? s : u;

    // Each 16-bit register occupies two adjacent byte slots; pull order is push order reversed
    assign psh_vec = {mask[0], mask[1], mask[2], mask[3],
                      mask[4], mask[4], mask[5], mask[5],
                      mask[6], mask[6], mask[7], mask[7]};
    assign pul_vec = {mask[7], mask[7], mask[6], mask[6],
                      mask[5], mask[5], mask[4], mask[4],
                      mask[3], mask[2], mask[1], mask[0]};

    // Pick the earliest pending byte in transfer order
    always_comb begin
        cur_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (pend[i]) cur_idx = 4'(i);
        end
    end

    assign cur_bit = 12'b1 << cur_idx;
    assign slot    = dir_psh ? cur_idx : (4'd11 - cur_idx);
    assign last    = (pend & ~cur_bit) == 12'd0;
    assign step    = cen && (st == XFER) && !mem.mem_busy;

    // Decode register select and byte half from the push-order slot
    always_comb begin
        cur_sel = 3'd0;
        cur_hi  = 1'b0;
        if (slot < 4'd8) begin
            cur_sel = 3'd7 - slot[3:1];
            cur_hi  = slot[0];
        end else begin
            cur_sel = 3'(4'd11 - slot);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        st_nxt       = st;
        busy         = 1'b0;
        done         = 1'b0;
        sp_we        = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_dout = 8'd0;
        mem.mem_addr = dir_psh ? (sp_out - AW'(1)) : sp_out;
        case (st)
            IDLE: begin
                if (start) st_nxt = (mask != 8'd0) ? XFER : FIN;
            end
            XFER: begin
                busy         = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_we   = dir_psh;
                mem.mem_dout = dir_psh ? byte_q[slot] : 8'd0;
                if (step && last) st_nxt = FIN;
            end
            FIN: begin
                done  = 1'b1;
                sp_we = 1'b1;
                if (cen) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Operand latch, byte walk, stack pointer update and pulled-byte strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_psh <= 1'b0;
            pend    <= 12'd0;
            byte_q  <= '0;
            sp_out  <= '0;
            ld_en   <= 1'b0;
            ld_sel  <= 3'd0;
            ld_hi   <= 1'b0;
            ld_data <= 8'd0;
            err     <= 1'b0;
        end else if (cen) begin
            err   <= conflict;
            ld_en <= 1'b0;
            if (start) begin
                dir_psh <= psh_go;
                pend    <= psh_go ? psh_vec : pul_vec;
                sp_out  <= sp_in;
                byte_q  <= {cc, a, b, dp, x[15:8], x[7:0], y[15:8], y[7:0],
                            other_sp[15:8], other_sp[7:0], pc[15:8], pc[7:0]};
            end
            if (step) begin
                pend <= pend & ~cur_bit;
                if (dir_psh) begin
                    sp_out <= sp_out - AW'(1);
                end else begin
                    sp_out  <= sp_out + AW'(1);
                    ld_en   <= 1'b1;
                    ld_sel  <= cur_sel;
                    ld_hi   <= cur_hi;
                    ld_data <= mem.mem_din;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// tb/tb_jtkcpu_stack_seq.sv - scoreboard bench for jtkcpu_stack_seq
module tb_jtkcpu_stack_seq;
    logic        clk, rst, cen;
    logic        psh_go, pul_go, use_u;
    logic [7:0]  mask;
    logic [15:0] sp_in, pc, u, s, y, x;
    logic [7:0]  dp, b, a, cc;
    logic [15:0] sp_out;
    logic        sp_we, ld_en, ld_hi, busy, done, err;
    logic [2:0]  ld_sel;
    logic [7:0]  ld_data;
    logic        mem_busy_r;
    logic        rnd;
    logic        saw_req;
    logic [7:0]  memory [0:65535];

    int n_chk  = 0;
    int n_pass = 0;

    logic [23:0] exp_wr[$];
    logic [11:0] exp_ld[$];
    logic [15:0] exp_done[$];

    jtkcpu_stack_seq_if #(.AW(16)) bus ();

    assign bus.mem_busy = mem_busy_r;
    assign bus.mem_din  = memory[bus.mem_addr];

    jtkcpu_stack_seq #(.AW(16)) dut (
        .rst(rst), .clk(clk), .cen(cen),
        .psh_go(psh_go), .pul_go(pul_go), .mask(mask), .use_u(use_u), .sp_in(sp_in),
        .pc(pc), .u(u), .s(s), .y(y), .x(x), .dp(dp), .b(b), .a(a), .cc(cc),
        .mem(bus.master),
        .sp_out(sp_out), .sp_we(sp_we), .ld_en(ld_en), .ld_sel(ld_sel), .ld_hi(ld_hi),
        .ld_data(ld_data), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Memory model: a byte write lands when the bus completes it
    always @(posedge clk) begin
        if (!rst && cen && bus.mem_req && !bus.mem_busy && bus.mem_we)
            memory[bus.mem_addr] = bus.mem_dout;
    end

    // Random wait states and clock enable while rnd is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) begin
                mem_busy_r = 1'($urandom_range(0, 1));
                cen        = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops expected events as the DUT presents them
    logic        hold_v;
    logic [24:0] hold_val;
    initial hold_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (bus.mem_req) saw_req = 1'b1;
            if (hold_v && bus.mem_req)
                chk("hold", {7'd0, bus.mem_we, bus.mem_addr, bus.mem_dout}, {7'd0, hold_val});
            hold_v   = bus.mem_req && (bus.mem_busy || !cen);
            hold_val = {bus.mem_we, bus.mem_addr, bus.mem_dout};
            if (cen && bus.mem_req && !bus.mem_busy && bus.mem_we) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", {bus.mem_addr, bus.mem_dout}, 32'hFFFF_FFFF);
                else chk("wr", {bus.mem_addr, bus.mem_dout}, exp_wr.pop_front());
            end
            if (cen && ld_en) begin
                if (exp_ld.size() == 0) chk("ld_unexpected", {ld_sel, ld_hi, ld_data}, 32'hFFFF_FFFF);
                else chk("ld", {ld_sel, ld_hi, ld_data}, exp_ld.pop_front());
            end
            if (cen && (done || sp_we)) begin
                chk("done_sp_we", {done, sp_we}, 2'b11);
                if (exp_done.size() == 0) chk("done_unexpected", sp_out, 32'hFFFF_FFFF);
                else chk("done_sp", sp_out, exp_done.pop_front());
            end
        end
    end

    task automatic go(input bit p, input bit q, input logic [7:0] m, input bit uu, input logic [15:0] sp);
        mask   = m;
        use_u  = uu;
        sp_in  = sp;
        psh_go = p;
        pul_go = q;
        @(posedge clk);
        #1;
        psh_go = 1'b0;
        pul_go = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        bit seen = 0;
        cyc = 1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done && cen) seen = 1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    int lat;

    initial begin
        rst = 1'b1; cen = 1'b1; psh_go = 1'b0; pul_go = 1'b0; use_u = 1'b0;
        mask = 8'd0; sp_in = 16'd0; mem_busy_r = 1'b0; rnd = 1'b0; saw_req = 1'b0;
        pc = 16'hA1B2; u = 16'hC3D4; s = 16'h5566; y = 16'hE5F6; x = 16'h0718;
        dp = 8'h29; b = 8'h34; a = 8'h12; cc = 8'h5C;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {bus.mem_req, bus.mem_we, busy, done, ld_en, sp_we, err}, 7'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: PSHS A,B
        exp_wr.push_back({16'h0FFF, 8'h34});
        exp_wr.push_back({16'h0FFE, 8'h12});
        exp_done.push_back(16'h0FFE);
        go(1, 0, 8'h06, 0, 16'h1000);
        wait_done(lat);
        chk("t1_latency", lat, 3);

        // 2: PULS CC,PC
        memory[16'h0FFD] = 8'h5A; memory[16'h0FFE] = 8'h80; memory[16'h0FFF] = 8'h00;
        exp_ld.push_back({3'd0, 1'b0, 8'h5A});
        exp_ld.push_back({3'd7, 1'b1, 8'h80});
        exp_ld.push_back({3'd7, 1'b0, 8'h00});
        exp_done.push_back(16'h1000);
        go(0, 1, 8'h81, 0, 16'h0FFD);
        wait_done(lat);
        chk("t2_latency", lat, 4);

        // 3: full push from 0x0000, zero wait then random wait/cen
        a = 8'h4B; b = 8'h3A;
        for (int r = 0; r < 2; r++) begin
            exp_wr.push_back({16'hFFFF, 8'hB2}); exp_wr.push_back({16'hFFFE, 8'hA1});
            exp_wr.push_back({16'hFFFD, 8'hD4}); exp_wr.push_back({16'hFFFC, 8'hC3});
            exp_wr.push_back({16'hFFFB, 8'hF6}); exp_wr.push_back({16'hFFFA, 8'hE5});
            exp_wr.push_back({16'hFFF9, 8'h18}); exp_wr.push_back({16'hFFF8, 8'h07});
            exp_wr.push_back({16'hFFF7, 8'h29}); exp_wr.push_back({16'hFFF6, 8'h3A});
            exp_wr.push_back({16'hFFF5, 8'h4B}); exp_wr.push_back({16'hFFF4, 8'h5C});
            exp_done.push_back(16'hFFF4);
            go(1, 0, 8'hFF, 0, 16'h0000);
            rnd = (r == 1);
            wait_done(lat);
            rnd = 1'b0; cen = 1'b1; mem_busy_r = 1'b0;
            if (r == 0) chk("t3_latency", lat, 13);
        end
        chk("t3_mem_cc", memory[16'hFFF4], 8'h5C);

        // 4: empty mask, then conflicting starts
        @(posedge clk); #1;
        saw_req = 1'b0;
        exp_done.push_back(16'h4321);
        go(1, 0, 8'h00, 0, 16'h4321);
        wait_done(lat);
        chk("t4_latency", lat, 1);
        go(1, 1, 8'h06, 0, 16'h1000);
        @(negedge clk);
        chk("t4_err", {err, busy}, 2'b10);
        @(negedge clk);
        chk("t4_err_clear", err, 0);
        repeat (3) @(negedge clk);
        chk("t4_idle", {busy, saw_req}, 2'b00);
        @(posedge clk); #1;

        // 5: PULU other-SP (S)
        memory[16'h2000] = 8'h9A; memory[16'h2001] = 8'hBC;
        exp_ld.push_back({3'd6, 1'b1, 8'h9A});
        exp_ld.push_back({3'd6, 1'b0, 8'hBC});
        exp_done.push_back(16'h2002);
        go(0, 1, 8'h40, 1, 16'h2000);
        wait_done(lat);
        chk("t5_latency", lat, 3);

        // 6: reset after the third byte of a full push, then a clean push
        exp_wr.push_back({16'h0FFF, 8'hB2});
        exp_wr.push_back({16'h0FFE, 8'hA1});
        exp_wr.push_back({16'h0FFD, 8'hD4});
        go(1, 0, 8'hFF, 0, 16'h1000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", {bus.mem_req, busy, done, sp_we, ld_en}, 5'd0);
        @(posedge clk); #1;
        a = 8'h77; b = 8'h88;
        exp_wr.push_back({16'h2FFF, 8'h88});
        exp_wr.push_back({16'h2FFE, 8'h77});
        exp_done.push_back(16'h2FFE);
        go(1, 0, 8'h06, 0, 16'h3000);
        wait_done(lat);
        chk("t6_latency", lat, 3);

        repeat (3) @(posedge clk);
        chk("left_wr", exp_wr.size(), 0);
        chk("left_ld", exp_ld.size(), 0);
        chk("left_done", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
